// File: rtl/stream_pool2d_if.sv
// Stream bundle for stream_pool2d: pixel input handshake and pooled output
// handshake. The slave modport is the pooling block's view, the master
// modport is the view of whatever drives it and consumes its results.
interface stream_pool2d_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] pixel_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_pool2d.sv
// stream_pool2d: streaming 2x2 / stride-2 pooling of a raster-order,
// channel-interleaved pixel stream with valid/ready on both sides.
// Default build pools with the signed maximum. Defining the macro
// POOL_AVG_EN switches to the floor average of the four window pixels;
// the pair and line-buffer storage then widen by one bit so the sums
// never overflow.
module stream_pool2d #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int CH     = 1
) (
  input  logic           clk,
  input  logic           rst,
  stream_pool2d_if.slave bus
);

  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int LB_N = (IMG_W / 2) * CH;
  localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;
`ifdef POOL_AVG_EN
  localparam int PW   = DATA_W + 1;
`else
  localparam int PW   = DATA_W;
`endif

  // Array depths are rounded up to a power of two so the index width is exact.
  logic        [CW-1:0]     ch_r;
  logic        [XW-1:0]     col_r;
  logic        [YW-1:0]     row_r;
  logic signed [DATA_W-1:0] hreg_r [0:(1<<CW)-1];
  logic signed [PW-1:0]     lb_r   [0:(1<<LBW)-1];

  logic                     out_valid_r;
  logic signed [DATA_W-1:0] out_data_r;
  logic                     out_last_r;

  logic                     in_ready_s;
  logic                     accept_s;
  logic                     last_ch_s;
  logic                     last_col_s;
  logic                     last_row_s;
  logic        [LBW-1:0]    lb_idx_s;
  logic signed [DATA_W-1:0] hreg_cur_s;
  logic signed [PW-1:0]     lb_cur_s;
  logic signed [PW-1:0]     pair_s;
  logic signed [DATA_W-1:0] result_s;
`ifdef POOL_AVG_EN
  logic signed [DATA_W+1:0] win_s;
`endif

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_ready_s    = !out_valid_r || bus.out_ready;
  assign accept_s      = bus.in_valid && in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  // Position decode, storage lookup and the pooling operator for the current pixel.
  always_comb begin
    last_ch_s  = (ch_r  == CW'(CH - 1));
    last_col_s = (col_r == XW'(IMG_W - 1));
    last_row_s = (row_r == YW'(IMG_H - 1));
    lb_idx_s   = LBW'((int'(col_r) / 2) * CH + int'(ch_r));
    hreg_cur_s = hreg_r[ch_r];
    lb_cur_s   = lb_r[lb_idx_s];
`ifdef POOL_AVG_EN
    pair_s     = PW'(hreg_cur_s) + PW'(bus.pixel_in);
    win_s      = (DATA_W+2)'(lb_cur_s) + (DATA_W+2)'(pair_s);
    result_s   = DATA_W'(win_s >>> 2);
`else
    pair_s     = smax(hreg_cur_s, bus.pixel_in);
    result_s   = smax(lb_cur_s, pair_s);
`endif
  end

  // Channel / column / row counters advance only on accepted pixels and wrap per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_r  <= {CW{1'b0}};
      col_r <= {XW{1'b0}};
      row_r <= {YW{1'b0}};
    end else if (accept_s) begin
      if (last_ch_s) begin
        ch_r <= {CW{1'b0}};
        if (last_col_s) begin
          col_r <= {XW{1'b0}};
          row_r <= last_row_s ? {YW{1'b0}} : row_r + YW'(1);
        end else begin
          col_r <= col_r + XW'(1);
        end
      end else begin
        ch_r <= ch_r + CW'(1);
      end
    end
  end

  // Horizontal register captures the even-column pixel of each channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << CW); i++) begin
        hreg_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s && !col_r[0]) begin
      hreg_r[ch_r] <= bus.pixel_in;
    end
  end

  // Line buffer keeps the even-row pair results; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept_s && col_r[0] && !row_r[0]) begin
      lb_r[lb_idx_s] <= pair_s;
    end
  end

  // Output register: a completed window loads it, otherwise a downstream handshake drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (accept_s && col_r[0] && row_r[0]) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
      out_last_r  <= last_ch_s && last_col_s && last_row_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2d.sv
// Directed bench for stream_pool2d: an 8x8 single-channel instance and an
// 8x8 two-channel instance share clock and reset. Inputs change 1 time unit
// after the rising edge; DUT outputs are sampled on the falling edge.
module tb_stream_pool2d;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_pool2d_if #(.DATA_W(8)) bus1 ();
  stream_pool2d_if #(.DATA_W(8)) bus2 ();

  stream_pool2d #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .CH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  stream_pool2d #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .CH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         stall_cnt = 0;
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  // Record {last, data} of every output handshake that the next rising edge completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.out_valid && bus1.out_ready) q1.push_back({bus1.out_last, bus1.out_data});
      if (bus2.out_valid && bus2.out_ready) q2.push_back({bus2.out_last, bus2.out_data});
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic send(input int which, input logic signed [7:0] v);
    int waited = 0;
    bit ok = 1'b0;
    if (which == 1) begin bus1.in_valid = 1'b1; bus1.pixel_in = v; end
    else            begin bus2.in_valid = 1'b1; bus2.pixel_in = v; end
    while (!ok && waited < 200) begin
      @(negedge clk);
      if ((which == 1) ? bus1.in_ready : bus2.in_ready) ok = 1'b1;
      else begin waited++; stall_cnt++; end
      @(posedge clk);
      #1;
    end
    if (which == 1) bus1.in_valid = 1'b0;
    else            bus2.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'sd1);
  endtask

  // mode 0: ch0 = 8r+c, ch1 = -(8r+c). mode 1: top-left window {-128,-1,-5,-7}, rest 0.
  function automatic logic signed [7:0] px(input int mode, input int r, input int c, input int chn);
    if (mode == 0) return (chn == 0) ? 8'(8 * r + c) : 8'(-(8 * r + c));
    if (r == 0 && c == 0) return -8'sd128;
    if (r == 0 && c == 1) return -8'sd1;
    if (r == 1 && c == 0) return -8'sd5;
    if (r == 1 && c == 1) return -8'sd7;
    return 8'sd0;
  endfunction

  task automatic send_frame(input int which, input int mode, input int n_ch);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < n_ch; k++)
          send(which, px(mode, r, c, k));
  endtask

  // Expected pooled value of window (i,j) for the mode-0 image.
  function automatic int exp_win(input int chn, input int i, input int j);
    int k = 16 * i + 2 * j;
`ifdef POOL_AVG_EN
    return (chn == 0) ? k + 4 : -k - 5;
`else
    return (chn == 0) ? k + 9 : -k;
`endif
  endfunction

  task automatic check_outs(input int which, input int n_ch, input int start);
    int idx = start;
    logic [8:0] e;
    logic signed [7:0] d;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < n_ch; k++) begin
          e = (which == 1) ? q1[idx] : q2[idx];
          d = e[7:0];
          chk($sformatf("out_data[%0d]", idx), d, exp_win(k, i, j));
          chk($sformatf("out_last[%0d]", idx), 32'(e[8]),
              32'((i == 3 && j == 3 && k == n_ch - 1) ? 1 : 0));
          idx++;
        end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus1.out_valid), 32'sd0);
    chk({tag, "_data"},  32'(bus1.out_data),  32'sd0);
    chk({tag, "_last"},  32'(bus1.out_last),  32'sd0);
    chk({tag, "_ready"}, 32'(bus1.in_ready),  32'sd1);
  endtask

  initial begin
    logic signed [7:0] d;
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.pixel_in = 8'sd0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.pixel_in = 8'sd0; bus2.out_ready = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(1);

    // Full-rate single-channel frame.
    stall_cnt = 0;
    send_frame(1, 0, 1);
    tick(3);
    chk("full_count", q1.size(), 32'sd16);
    check_outs(1, 1, 0);
    chk("full_stalls", stall_cnt, 32'sd0);

    // Negative window.
    q1.delete();
    send_frame(1, 1, 1);
    tick(3);
    chk("neg_count", q1.size(), 32'sd16);
    d = q1[0][7:0];
`ifdef POOL_AVG_EN
    chk("neg_window", d, -32'sd36);
`else
    chk("neg_window", d, -32'sd1);
`endif
    chk("neg_last", 32'(q1[15][8]), 32'sd1);

    // Two interleaved channels.
    stall_cnt = 0;
    send_frame(2, 0, 2);
    tick(3);
    chk("ch2_count", q2.size(), 32'sd32);
    check_outs(2, 2, 0);
    chk("ch2_stalls", stall_cnt, 32'sd0);

    // Backpressure from the start of the frame.
    q1.delete();
    bus1.out_ready = 1'b0;
    for (int p = 0; p < 10; p++) send(1, 8'(p));
    bus1.in_valid = 1'b1;
    bus1.pixel_in = 8'sd10;
    @(negedge clk);
    chk("bp_in_ready", 32'(bus1.in_ready), 32'sd0);
    chk("bp_valid", 32'(bus1.out_valid), 32'sd1);
    d = bus1.out_data;
    chk("bp_data", d, 32'sd9);
    repeat (4) @(negedge clk);
    d = bus1.out_data;
    chk("bp_hold_data", d, 32'sd9);
    chk("bp_hold_ready", 32'(bus1.in_ready), 32'sd0);
    @(posedge clk); #1;
    bus1.out_ready = 1'b1;
    for (int p = 10; p < 64; p++) send(1, 8'(p));
    tick(3);
    chk("bp_count", q1.size(), 32'sd16);
    check_outs(1, 1, 0);

    // Reset in the middle of a frame, then two frames back to back.
    for (int p = 0; p < 20; p++) send(1, 8'(p));
    tick(1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    send_frame(1, 0, 1);
    send_frame(1, 0, 1);
    tick(3);
    chk("rst_count", q1.size(), 32'sd32);
    check_outs(1, 1, 0);
    check_outs(1, 1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_pool2d.md
# stream_pool2d

Streaming 2×2, stride-2 pooling stage for the CNN datapath. It takes a raster-order, channel-interleaved pixel stream, normally the conv/ReLU output of the convolution top, and emits one pooled value per 2×2 window per channel. It generalises the fixed single-channel pool stage: image width, height and channel count are parameters, both sides use a valid/ready handshake with backpressure, and frame boundaries are tracked and marked.

## Interface
- DATA_W, 8: signed pixel width (two's complement).
- IMG_W, 8: input image width in pixels. Even, ≥2.
- IMG_H, 8: input image height in pixels. Even, ≥2.
- CH, 1: channels interleaved per pixel position. ≥1.

Ports (single clock domain; reset is asynchronous and active-high):
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel_in is valid.
- in_ready  out  1  block accepts pixel_in. Equals !out_valid || out_ready (combinational).
- pixel_in  in  DATA_W  signed input pixel.
- out_valid  out  1  out_data and out_last are valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  DATA_W  signed pooled value.
- out_last  out  1  marks the final pooled value of a frame.

## Operation
- Accept occurs when in_valid && in_ready. Only accepted pixels advance the counters.
- Input order per frame: row 0..IMG_H-1, then col 0..IMG_W-1, then ch 0..CH-1 (channel counter fastest).
- Counters ch, col, row wrap to 0 after the last pixel of a frame. The next frame may start on the following cycle with no gap.
- Per-channel horizontal register hreg[CH]:
  - Even col: hreg[ch] ← pixel.
  - Odd col: pair = op(hreg[ch], pixel).
- Line buffer lb holds (IMG_W/2)·CH entries, indexed by (col>>1, ch).
  - Even row, odd col: lb ← pair.
  - Odd row, odd col: result = op(lb, pair). result is loaded into the output register; out_valid is set.
- op is the signed maximum, unless the POOL_AVG_EN macro is defined (see Configuration).
- out_last = 1 when the result comes from row IMG_H-1, col IMG_W-1, ch CH-1.
- Outputs per frame: (IMG_W/2)·(IMG_H/2)·CH, in raster order, channel-interleaved.
- Output register:
  - New result loads it.
  - Otherwise, out_valid && out_ready clears out_valid and out_last.
  - A new result arriving in the same cycle as a handshake reloads the register; nothing is lost.
- Backpressure: while out_valid && !out_ready, in_ready = 0. out_data and out_last stay stable.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0.
  - All counters = 0, hreg = 0.
  - in_ready = 1.
  - lb contents are don't-care; each entry is written before it is read.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (row 0, col 0, ch 0).

## Timing
- Latency: out_valid asserts in the cycle after the accept of the window's 4th pixel (odd row, odd col). The output register is the only pipeline stage.
- Full-rate throughput with out_ready held at 1: no input stall cycles.
- No combinational path from pixel_in to out_data.
- The only combinational input→output path is out_ready→in_ready.

## Configuration
- POOL_AVG_EN not defined: op = signed max. lb and hreg are DATA_W wide.
- POOL_AVG_EN defined: op = signed sum.
  - Pair sum is DATA_W+1 wide; lb and the stored pair are DATA_W+1 wide.
  - Window sum is DATA_W+2 wide.
  - out_data = window sum >>> 2 (arithmetic shift, floor), truncated to DATA_W. The result always fits.
  - Handshake, latency and ordering are unchanged.

## Test plan
- 8×8, CH=1, image[r][c] = 8r+c, out_ready=1, max mode → outputs 9,11,13,15,25,27,29,31,41,…,63. Exactly 16 outputs; out_last only on 63; no in_ready stall.
- Same image with POOL_AVG_EN defined → first row of outputs 4,6,8,10 (e.g. (0+1+8+9)/4 = 4.5 → 4); last output 58.
- Negative values: window {-128,-1,-5,-7} → max −1. With POOL_AVG_EN: sum −141 → −36.
- CH=2, ch0 = 8r+c, ch1 = −(8r+c), max mode → outputs alternate ch0/ch1: 9,0,11,−2,13,−4,15,−6,…; out_last on the ch1 output of the final window.
- Backpressure: hold out_ready=0 from the start → in_ready drops the cycle after the first output. out_data is held at 9 until out_ready=1. The total output sequence matches the full-rate run.
- Assert rst after 20 accepted pixels, then send two full frames back to back → exactly 32 outputs. Each frame starts with 9; out_last at outputs 16 and 32. All outputs read 0 during reset.
